// File: rtl/wb_write_arbiter_if.sv
// Register-file write port bundle: pipeline writeback, multi-cycle
// valid/ready channel, registered write port and hazard-unit status.
interface wb_write_arbiter_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
);
    logic                       pipe_valid;
    logic [4:0]                 pipe_rd;
    logic [XLEN-1:0]            pipe_data;
    logic                       mc_valid;
    logic                       mc_ready;
    logic [4:0]                 mc_rd;
    logic [XLEN-1:0]            mc_data;
    logic                       RegWrite;
    logic [4:0]                 rd;
    logic [XLEN-1:0]            write_data;
    logic [31:0]                busy_mask;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic                       stall_req;

    // Result producers and register-file/hazard consumers
    modport master (
        output pipe_valid, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        input  mc_ready, RegWrite, rd, write_data, busy_mask, fifo_count, stall_req
    );

    // The arbiter itself
    modport slave (
        input  pipe_valid, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        output mc_ready, RegWrite, rd, write_data, busy_mask, fifo_count, stall_req
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: pipeline results always win the register-file port;
// multi-cycle results wait in an in-order FIFO and drain on idle cycles.
// A starve counter requests a pipeline bubble when the FIFO waits too long.
module wb_write_arbiter #(
    parameter int XLEN         = 64,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_write_arbiter_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]   cnt;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [DEPTH-1:0] slot_vld;
    logic [4:0]      slot_rd   [DEPTH];
    logic [XLEN-1:0] slot_data [DEPTH];
    logic [SW-1:0]   starve;
    logic [31:0]     mask;

    logic pipe_win;
    logic push;
    logic pop;
    logic fifo_empty;

    // Ready depends only on registered occupancy, never on the valids
    assign bus.mc_ready = !reset && (cnt < CW'(DEPTH));
    assign fifo_empty   = (cnt == '0);
    assign pipe_win     = bus.pipe_valid && (bus.pipe_rd != 5'd0);
    // x0 results finish the handshake but are dropped
    assign push         = bus.mc_valid && bus.mc_ready && (bus.mc_rd != 5'd0);
    assign pop          = !pipe_win && !fifo_empty;

    assign bus.fifo_count = cnt;
    assign bus.busy_mask  = mask;

    // FIFO control: pointers, occupancy and per-slot valid bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            slot_vld <= '0;
        end else begin
            // Push and pop never target the same slot: that needs full or empty
            if (pop) begin
                slot_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (push) begin
                slot_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // FIFO payload storage; contents are qualified by slot_vld
    always_ff @(posedge clk) begin
        if (push) begin
            slot_rd[wr_ptr]   <= bus.mc_rd;
            slot_data[wr_ptr] <= bus.mc_data;
        end
    end

    // Pending-destination mask: OR of one-hot rd over occupied slots
    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i]) mask[slot_rd[i]] = 1'b1;
        end
    end

    // Registered write port: pipeline first, else FIFO head, else hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.RegWrite   <= 1'b0;
            bus.rd         <= 5'd0;
            bus.write_data <= '0;
        end else if (pipe_win) begin
            bus.RegWrite   <= 1'b1;
            bus.rd         <= bus.pipe_rd;
            bus.write_data <= bus.pipe_data;
        end else if (pop) begin
            bus.RegWrite   <= 1'b1;
            bus.rd         <= slot_rd[rd_ptr];
            bus.write_data <= slot_data[rd_ptr];
        end else begin
            bus.RegWrite   <= 1'b0;
        end
    end

    // Starvation tracking: one-cycle stall request after STARVE_LIMIT blocked cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve        <= '0;
            bus.stall_req <= 1'b0;
        end else begin
            bus.stall_req <= 1'b0;
            if (pop || fifo_empty) begin
                starve <= '0;
            end else if (pipe_win) begin
                if (starve == SW'(STARVE_LIMIT - 1)) begin
                    starve        <= '0;
                    bus.stall_req <= 1'b1;
                end else begin
                    starve <= starve + 1'b1;
                end
            end
        end
    end
endmodule
